asteroid_draw_seq: RTL and testbench

Upstream sequencer for the asteroid sprite-draw stage. On each frame-start pulse it walks the asteroid state table slot by slot. For every active slot it presents that asteroid's position and sprite select to the asteroid draw stage, pulses `plot`, and waits for `draw_done` before moving on. When the walk finishes it reports frame completion and a count of drawn asteroids to the frame controller.

---
 rtl/asteroid_draw_seq.sv | 123 ++++++++++++
 tb/tb_asteroid_draw_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/asteroid_draw_seq.sv
// rtl/asteroid_draw_seq.sv - per-frame walk of the asteroid table, one plot/draw_done handshake per active slot
// Optional: define ASTEROID_CULL_EN to skip active slots whose top-left lies off the 640x480 screen.
module asteroid_draw_seq #(
  parameter int NUM_AST = 8,
  parameter int IDX_W   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  output logic [IDX_W-1:0] ast_idx,
  input  logic             ast_active,
  input  logic [9:0]       ast_x,
  input  logic [9:0]       ast_y,
  input  logic [2:0]       ast_sprite,
  output logic [9:0]       x_pos,
  output logic [9:0]       y_pos,
  output logic [2:0]       sprite_sel,
  output logic             plot,
  input  logic             draw_done,
  output logic             busy,
  output logic             frame_done,
  output logic [4:0]       drawn_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLOT,
    S_WAIT,
    S_NEXT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_AST - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             slot_ok;
  logic             last_slot;

`ifdef ASTEROID_CULL_EN
  assign slot_ok = ast_active && (ast_x < 10'd640) && (ast_y < 10'd480);
`else
  assign slot_ok = ast_active;
`endif

  assign last_slot = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    plot       = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (frame_start) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: state_nxt = slot_ok ? S_PLOT : S_NEXT;
      S_PLOT: begin
        plot      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (draw_done) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        frame_done = last_slot;
        state_nxt  = last_slot ? S_IDLE : S_FETCH;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Draw outputs change only in LATCH, so they hold through PLOT/WAIT and across frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      sprite_sel  <= '0;
      drawn_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            idx         <= '0;
            drawn_count <= '0;
          end
        end
        S_LATCH: begin
          if (slot_ok) begin
            x_pos      <= ast_x;
            y_pos      <= ast_y;
            sprite_sel <= ast_sprite;
          end
        end
        S_WAIT: begin
          if (draw_done && (drawn_count != 5'd31)) drawn_count <= drawn_count + 5'd1;
        end
        S_NEXT: begin
          if (!last_slot) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ast_idx = idx;

endmodule

// File: tb/tb_asteroid_draw_seq.sv
// tb/tb_asteroid_draw_seq.sv - scoreboard bench for asteroid_draw_seq (honours ASTEROID_CULL_EN)
module tb_asteroid_draw_seq;

  localparam int NUM_AST = 8;
  localparam int IDX_W   = 3;
  localparam int LIMIT   = 400;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             fs_main, fs_spur;
  logic             frame_start;
  logic [IDX_W-1:0] ast_idx;
  logic             ast_active;
  logic [9:0]       ast_x, ast_y;
  logic [2:0]       ast_sprite;
  logic [9:0]       x_pos, y_pos;
  logic [2:0]       sprite_sel;
  logic             plot;
  logic             dd_model, dd_spur;
  logic             draw_done;
  logic             busy;
  logic             frame_done;
  logic [4:0]       drawn_count;

  assign frame_start = fs_main | fs_spur;
  assign draw_done   = dd_model | dd_spur;

  always #5 clk = ~clk;

  asteroid_draw_seq #(.NUM_AST(NUM_AST), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .ast_idx(ast_idx),
    .ast_active(ast_active), .ast_x(ast_x), .ast_y(ast_y), .ast_sprite(ast_sprite),
    .x_pos(x_pos), .y_pos(y_pos), .sprite_sel(sprite_sel), .plot(plot),
    .draw_done(draw_done), .busy(busy), .frame_done(frame_done), .drawn_count(drawn_count)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] spr;
  } plot_t;

  plot_t sb[$];
  plot_t cur;
  logic       tbl_act[NUM_AST];
  logic [9:0] tbl_x[NUM_AST];
  logic [9:0] tbl_y[NUM_AST];
  logic [2:0] tbl_spr[NUM_AST];

  int n_vec = 0;
  int n_err = 0;
  int plot_count = 0;
  bit in_draw = 0;
  int lat = 10;
  bit disturb = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Table RAM: registered read, data one cycle after ast_idx.
  initial forever begin
    @(posedge clk);
    ast_active <= tbl_act[ast_idx];
    ast_x      <= tbl_x[ast_idx];
    ast_y      <= tbl_y[ast_idx];
    ast_sprite <= tbl_spr[ast_idx];
  end

  // Draw stage: draw_done lat cycles after plot; optional spurious frame_start in WAIT and draw_done in FETCH.
  initial begin
    int cnt, post, fsc;
    bit pending;
    pending = 0; cnt = 0; post = 0; fsc = 0;
    dd_model = 0; dd_spur = 0; fs_spur = 0;
    forever begin
      @(negedge clk);
      dd_model = 0; dd_spur = 0; fs_spur = 0;
      if (!reset_n) begin
        pending = 0; post = 0; fsc = 0;
      end else begin
        if (pending) begin
          if (cnt == 1) begin
            dd_model = 1; pending = 0; post = 2;
          end else cnt--;
        end else if (post > 0) begin
          post--;
          if (post == 0 && disturb) dd_spur = 1;
        end
        if (fsc > 0) begin
          fsc--;
          if (fsc == 0 && disturb) fs_spur = 1;
        end
        if (plot) begin
          pending = 1; cnt = lat; fsc = 2;
        end
      end
    end
  end

  // Monitor: pop expected plot on each plot pulse, check outputs hold until draw_done.
  initial forever begin
    plot_t e;
    @(negedge clk);
    if (!reset_n) in_draw = 0;
    else if (plot) begin
      plot_count++;
      if (sb.size() == 0) check("plot_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("plot_idx", 32'(ast_idx), 32'(e.idx));
        check("plot_x", 32'(x_pos), 32'(e.x));
        check("plot_y", 32'(y_pos), 32'(e.y));
        check("plot_spr", 32'(sprite_sel), 32'(e.spr));
        cur = e;
        in_draw = 1;
      end
    end else if (in_draw) begin
      check("draw_hold", 32'({x_pos, y_pos, sprite_sel}), 32'({cur.x, cur.y, cur.spr}));
      if (draw_done) in_draw = 0;
    end
  end

  function automatic bit drawable(input int i);
`ifdef ASTEROID_CULL_EN
    return tbl_act[i] && (tbl_x[i] < 10'd640) && (tbl_y[i] < 10'd480);
`else
    return tbl_act[i];
`endif
  endfunction

  task automatic push_expected(input int upto);
    for (int i = 0; i <= upto; i++)
      if (drawable(i)) sb.push_back('{idx: 3'(i), x: tbl_x[i], y: tbl_y[i], spr: tbl_spr[i]});
  endtask

  task automatic set_table(input logic [7:0] act);
    for (int i = 0; i < NUM_AST; i++) begin
      tbl_act[i] = act[i];
      tbl_x[i]   = 10'($urandom_range(0, 639));
      tbl_y[i]   = 10'($urandom_range(0, 479));
      tbl_spr[i] = 3'($urandom_range(0, 7));
    end
  endtask

  // Called at a negedge; returns cycle (negedges after request) of frame_done and first plot.
  task automatic run_frame(input int exp_cnt, output int done_cyc, output int first_plot);
    int cyc, p0;
    push_expected(NUM_AST - 1);
    p0 = plot_count;
    first_plot = -1;
    fs_main = 1;
    @(negedge clk);
    fs_main = 0;
    cyc = 1;
    check("fetch_busy", 32'(busy), 32'd1);
    check("fetch_idx0", 32'(ast_idx), 32'd0);
    while (!frame_done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (plot && first_plot < 0) first_plot = cyc;
    end
    done_cyc = cyc;
    check("frame_done_seen", 32'(frame_done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd1);
    check("drawn_count", 32'(drawn_count), 32'(exp_cnt));
    check("plot_total", 32'(plot_count - p0), 32'(exp_cnt));
    check("sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_pulse", 32'(frame_done), 32'd0);
    check("count_hold", 32'(drawn_count), 32'(exp_cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 32'({plot, frame_done, busy, ast_idx, drawn_count}), 32'd0);
    check({tag, "_pos"}, 32'({x_pos, y_pos, sprite_sel}), 32'd0);
  endtask

  initial begin
    int dc, fp, k;
    plot_t last;
    reset_n = 0; fs_main = 0;
    set_table(8'h00);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1;
    @(negedge clk);

    // All slots active, draw latency 10.
    set_table(8'hFF);
    run_frame(8, dc, fp);
    check("first_plot_cyc", 32'(fp), 32'd3);

    // Slots 1, 4, 7 only; slot 4 fixed.
    set_table(8'b1001_0010);
    tbl_x[4] = 10'd100; tbl_y[4] = 10'd50; tbl_spr[4] = 3'd5;
    run_frame(3, dc, fp);

    // Slot 2 off-screen in x, slot 5 on-screen.
    set_table(8'b0010_0100);
    tbl_x[2] = 10'd700;
`ifdef ASTEROID_CULL_EN
    run_frame(1, dc, fp);
`else
    run_frame(2, dc, fp);
`endif

    // Spurious frame_start in WAIT and draw_done in FETCH must be ignored.
    set_table(8'hFF);
    disturb = 1;
    run_frame(8, dc, fp);
    disturb = 0;
    k = plot_count;
    repeat (4) @(negedge clk);
    check("no_queued_frame", 32'(busy), 32'd0);
    check("no_extra_plot", 32'(plot_count - k), 32'd0);
    last = cur;

    // All inactive: 3 cycles per slot, previous draw outputs retained.
    set_table(8'h00);
    run_frame(0, dc, fp);
    check("idle_frame_cyc", 32'(dc), 32'd24);
    check("idle_no_plot", 32'(fp), 32'hFFFF_FFFF);
    check("pos_retained", 32'({x_pos, y_pos, sprite_sel}), 32'({last.x, last.y, last.spr}));

    // Reset in WAIT of slot 3.
    set_table(8'hFF);
    push_expected(3);
    fs_main = 1;
    @(negedge clk);
    fs_main = 0;
    k = 0;
    while (!(plot && ast_idx == 3'd3) && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("slot3_plot_seen", 32'(plot && ast_idx == 3'd3), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1 check_all_zero("midreset");
    check("midreset_sb", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    run_frame(8, dc, fp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
